// File: rtl/fetch_npc_unit.sv
// fetch_npc_unit: F-stage PC register, next-PC selection and F/D pipeline register.
// Branch/jump decisions use the instruction already in D, so the delay slot always executes.
module fetch_npc_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] im_instr,
    input  logic        cmp_true,
    input  logic [31:0] rs_fwd,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] link_d,
    output logic        addr_err
);
    logic [31:0] pcf_q, pcf_d, instr_q, pcd_q;
    logic        err_q, err_d;
    logic [5:0]  op, func;
    logic [4:0]  rt;
    logic        is_br, is_j, is_jr;

    assign op    = instr_q[31:26];
    assign rt    = instr_q[20:16];
    assign func  = instr_q[5:0];
    assign is_br = op == 6'b000100 || (op == 6'b000001 && rt == 5'b10001);
    assign is_j  = op == 6'b000010 || op == 6'b000011;
    assign is_jr = op == 6'b000000 && (func == 6'b001000 || func == 6'b001001);

    // cmp_true only matters for conditional branches, so X on it elsewhere is masked
    always_comb begin
        pcf_d = is_br && cmp_true ? pcd_q + 32'd4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00}
              : is_j              ? {pcd_q[31:28], instr_q[25:0], 2'b00}
              : is_jr             ? {rs_fwd[31:2], 2'b00}
              :                     pcf_q + 32'd4;
        err_d = err_q | (is_jr && rs_fwd[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcf_q   <= PC_RESET;
            instr_q <= NOP_INSTR;
            pcd_q   <= PC_RESET;
            err_q   <= 1'b0;
        end else if (!stall) begin
            pcf_q   <= pcf_d;
            instr_q <= im_instr;
            pcd_q   <= pcf_q;
            err_q   <= err_d;
        end
    end

    assign pc_f     = pcf_q;
    assign instr_d  = instr_q;
    assign pc_d     = pcd_q;
    assign link_d   = pcd_q + 32'd8;
    assign addr_err = err_q;
endmodule

// File: tb/tb_fetch_npc_unit.sv
// tb_fetch_npc_unit: directed stimulus with a per-cycle reference model of the fetch stage
// and hand-computed literal expectations for the key scenarios.
module tb_fetch_npc_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1, stall = 1'b0, cmp_true = 1'b0;
    logic [31:0] im_instr = '0, rs_fwd = '0;
    logic [31:0] pc_f, instr_d, pc_d, link_d;
    logic        addr_err;

    int n_chk = 0, n_fail = 0;

    logic [31:0] m_pcf, m_instr, m_pcd;
    logic        m_err;
    bit          m_valid = 0;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] ADD_A = 32'h2001_0001;
    localparam logic [31:0] ADD_B = 32'h2002_0002;
    localparam logic [31:0] ADD_C = 32'h2003_0003;
    localparam logic [31:0] BEQ_M = 32'h1000_FFFF;
    localparam logic [31:0] BGEZ4 = 32'h0411_0004;
    localparam logic [31:0] J_800 = 32'h0800_0800;
    localparam logic [31:0] JAL_T = 32'h0C00_0C10;
    localparam logic [31:0] JR_RA = 32'h03E0_0008;
    localparam logic [31:0] JALR  = 32'h0000_F809;

    fetch_npc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .im_instr(im_instr),
        .cmp_true(cmp_true), .rs_fwd(rs_fwd), .pc_f(pc_f), .instr_d(instr_d),
        .pc_d(pc_d), .link_d(link_d), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_npc(input logic [31:0] i, input logic [31:0] pcf,
                                              input logic [31:0] pcd, input logic c,
                                              input logic [31:0] rs);
        int unsigned op = i[31:26];
        int          off = int'($signed(i[15:0])) * 4;
        if (op == 4 || (op == 1 && i[20:16] == 5'd17)) return c ? pcd + 32'd4 + off : pcf + 32'd4;
        if (op == 2 || op == 3) return (pcd & 32'hF000_0000) | ({6'd0, i[25:0]} << 2);
        if (op == 0 && (i[5:0] == 6'd8 || i[5:0] == 6'd9)) return rs & ~32'd3;
        return pcf + 32'd4;
    endfunction

    task automatic cyc(input logic [31:0] im, input logic c, input logic [31:0] rs,
                       input logic st, input logic rst_n);
        logic [31:0] npc;
        logic        is_jr;
        im_instr = im; cmp_true = c; rs_fwd = rs; stall = st; reset = rst_n;
        @(posedge clk);
        if (!rst_n) begin
            m_pcf = 32'h3000; m_instr = NOP; m_pcd = 32'h3000; m_err = 0; m_valid = 1;
        end else if (!st) begin
            npc   = model_npc(m_instr, m_pcf, m_pcd, c, rs);
            is_jr = m_instr[31:26] == 0 && (m_instr[5:0] == 8 || m_instr[5:0] == 9);
            if (is_jr && rs[1:0] != 0) m_err = 1;
            m_pcd = m_pcf; m_instr = im; m_pcf = npc;
        end
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) if (m_valid) begin
        chk("cyc_pc_f", pc_f, m_pcf);
        chk("cyc_instr_d", instr_d, m_instr);
        chk("cyc_pc_d", pc_d, m_pcd);
        chk("cyc_link_d", link_d, m_pcd + 32'd8);
        chk("cyc_addr_err", {31'd0, addr_err}, {31'd0, m_err});
    end

    initial begin
        // T1 reset
        cyc(32'hDEAD_BEEF, 1, 32'h3, 1, 0);
        chk("t1_pc_f", pc_f, 32'h3000);
        chk("t1_instr_d", instr_d, 32'h0);
        chk("t1_pc_d", pc_d, 32'h3000);
        chk("t1_err", {31'd0, addr_err}, 32'd0);
        // T2 sequential fetch, cmp_true ignored for non-branches
        cyc(ADD_A, 1, 0, 0, 1);
        chk("t2_pc_f0", pc_f, 32'h3004); chk("t2_ins0", instr_d, ADD_A); chk("t2_pcd0", pc_d, 32'h3000);
        cyc(ADD_B, 1, 0, 0, 1);
        chk("t2_pc_f1", pc_f, 32'h3008); chk("t2_ins1", instr_d, ADD_B); chk("t2_pcd1", pc_d, 32'h3004);
        cyc(ADD_C, 0, 0, 0, 1);
        chk("t2_pc_f2", pc_f, 32'h300C); chk("t2_ins2", instr_d, ADD_C); chk("t2_pcd2", pc_d, 32'h3008);
        // T3 taken beq with negative offset
        cyc(NOP, 0, 0, 0, 0);
        cyc(NOP, 0, 0, 0, 1);
        cyc(BEQ_M, 0, 0, 0, 1);
        cyc(ADD_A, 1, 0, 0, 1);
        chk("t3_pc_f", pc_f, 32'h3004); chk("t3_slot", instr_d, ADD_A); chk("t3_pc_d", pc_d, 32'h3008);
        // T4 stalled beq redirects exactly once
        cyc(NOP, 0, 0, 0, 0);
        cyc(NOP, 0, 0, 0, 1);
        cyc(BEQ_M, 0, 0, 0, 1);
        cyc(ADD_B, 1, 0, 1, 1);
        cyc(ADD_B, 1, 0, 1, 1);
        chk("t4_hold_pcf", pc_f, 32'h3008); chk("t4_hold_ins", instr_d, BEQ_M); chk("t4_hold_pcd", pc_d, 32'h3004);
        cyc(ADD_B, 1, 0, 0, 1);
        chk("t4_redir", pc_f, 32'h3004);
        cyc(ADD_C, 1, 0, 0, 1);
        chk("t4_once", pc_f, 32'h3008);
        // T5 jal
        cyc(NOP, 0, 0, 0, 0);
        cyc(JAL_T, 0, 0, 0, 1);
        chk("t5_link", link_d, 32'h3008);
        cyc(NOP, 0, 0, 0, 1);
        chk("t5_pc_f", pc_f, 32'h0000_3040);
        // bgezal not taken, then taken; plain j
        cyc(NOP, 0, 0, 0, 0);
        cyc(BGEZ4, 0, 0, 0, 1);
        cyc(NOP, 0, 0, 0, 1);
        chk("bgez_nt", pc_f, 32'h3008);
        cyc(NOP, 0, 0, 0, 0);
        cyc(BGEZ4, 0, 0, 0, 1);
        cyc(NOP, 1, 0, 0, 1);
        chk("bgez_t", pc_f, 32'h3014);
        cyc(NOP, 0, 0, 0, 0);
        cyc(J_800, 0, 0, 0, 1);
        cyc(NOP, 0, 0, 0, 1);
        chk("j_pc_f", pc_f, 32'h2000);
        // jalr: misaligned rs during a stall must not set addr_err
        cyc(NOP, 0, 0, 0, 0);
        cyc(JALR, 0, 0, 0, 1);
        cyc(NOP, 0, 32'h4002, 1, 1);
        cyc(NOP, 0, 32'h4000, 0, 1);
        chk("jalr_pc_f", pc_f, 32'h4000);
        chk("jalr_err", {31'd0, addr_err}, 32'd0);
        // T6 jr misaligned sets sticky addr_err
        cyc(NOP, 0, 0, 0, 0);
        cyc(JR_RA, 0, 0, 0, 1);
        cyc(NOP, 0, 32'h3011, 0, 1);
        chk("t6_pc_f", pc_f, 32'h3010);
        chk("t6_err", {31'd0, addr_err}, 32'd1);
        cyc(NOP, 0, 32'h1, 0, 1);
        cyc(NOP, 0, 0, 0, 1);
        chk("t6_sticky", {31'd0, addr_err}, 32'd1);
        cyc(NOP, 0, 0, 0, 0);
        chk("t6_clear", {31'd0, addr_err}, 32'd0);
        // wrap-around of sequential fetch
        cyc(JR_RA, 0, 0, 0, 1);
        cyc(NOP, 0, 32'hFFFF_FFFC, 0, 1);
        chk("wrap_top", pc_f, 32'hFFFF_FFFC);
        cyc(NOP, 0, 0, 0, 1);
        chk("wrap_zero", pc_f, 32'h0);
        m_valid = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
